uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmit word channel between up to eight word sources: the control unit's state/statistics stream, trace, and debug dumps. Round-robin arbitration with burst locking: a granted source keeps the channel for as long as it holds its valid high. Each source sees the same hold-until-ack handshake the UART interface presents, so existing senders connect unchanged. Sits between the sources and the UART TX word interface.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- WORD_WIDTH, 16, transmit word width
- MAX_BURST, 0, words per grant before forced release; 0 = unlimited
- TIMEOUT_CYCLES, 1024, cycles without tx_ack before watchdog release (only with macro)

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global step enable; low freezes all registers
- req_word  in  NUM_REQ*WORD_WIDTH  packed source words; source i at [i*WORD_WIDTH +: WORD_WIDTH]
- req_valid  in  NUM_REQ  source i holds word; held until acked
- req_ack  out  NUM_REQ  word of source i accepted this cycle
- tx_word  out  WORD_WIDTH  word to UART
- tx_word_valid  out  1  tx_word valid; held until tx_ack
- tx_ack  in  1  UART accepted tx_word this cycle
- grant_id  out  3  index of current/last granted source
- busy  out  1  a grant is active
- timeout_error  out  1  sticky watchdog flag
- clear_error  in  1  synchronous clear of timeout_error

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping.
  - Next cycle: register grant_id, enter GRANT.
  - No req_valid: stay in IDLE.
- GRANT outputs (combinational):
  - tx_word = req_word[grant_id].
  - tx_word_valid = req_valid[grant_id] & enable.
  - req_ack[grant_id] = tx_word_valid & tx_ack; every other req_ack is 0.
- Leaving GRANT (enter IDLE next cycle, set rr_ptr = grant_id+1 mod NUM_REQ):
  - (a) req_valid[grant_id] is low for one cycle, or
  - (b) MAX_BURST != 0 and the acked-word count reaches MAX_BURST (on the ack cycle), or
  - (c) the watchdog fires.
- burst_cnt: width clog2(MAX_BURST+1), cleared on entering GRANT, increments per ack, saturates.
- A source that drops valid between words loses its lock and re-arbitrates.
- A source whose burst is cut by MAX_BURST keeps its word held. It loses no data and resumes after the other sources have had their turns.
- tx_ack with no grant, or with tx_word_valid low, is ignored.
- enable low:
  - Registers hold.
  - tx_word_valid and all req_ack are forced 0.
  - tx_word still shows the granted word.
- Reset (asserting reset_n low, including mid-burst):
  - State IDLE; rr_ptr, grant_id, burst_cnt and the watchdog counter go to 0.
  - busy, tx_word_valid, req_ack and timeout_error go to 0; tx_word goes to 0.
  - Any in-flight word is abandoned; the source re-presents it.

## Timing
- Grant latency: 1 cycle from req_valid rising in IDLE to tx_word_valid.
- Ack passthrough is 0 cycles (combinational tx_ack → req_ack).
- Re-arbitration bubble: exactly 1 IDLE cycle between consecutive grants.
- busy = (state == GRANT), registered.
- A source that releases and re-requests immediately gets the channel back only if no other source is valid in that IDLE cycle.

## Configuration
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter counts GRANT cycles with tx_word_valid high and tx_ack low; it resets on each ack.
  - On reaching TIMEOUT_CYCLES it forces release (rule c) and sets timeout_error.
  - timeout_error stays set until clear_error or reset. If clear_error and a new timeout occur in the same cycle, set wins.
- Undefined: no counter; timeout_error is tied 0; clear_error is ignored; TIMEOUT_CYCLES is unused.

## Structure
- Package uart_tx_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the grant_id width constant (3) and the maximum NUM_REQ (8);
  - a pure function next_rr(ptr, NUM_REQ).
- Sub-module rr_pick (combinational) takes the request vector and rr_ptr and returns found and index. It is the only natural split.
- Arbiter, counters and output muxing stay in uart_tx_arbiter.

## Test plan
- Single source:
  - Stimulus: src0 holds valid for 4 words, tx_ack every 2nd cycle.
  - Required: tx_word_valid 1 cycle after request; exactly 4 req_ack[0] pulses; words in order; busy drops 1 cycle after valid drops.
- Fairness:
  - Stimulus: src0 and src1 continuously valid, MAX_BURST=2, tx_ack always 1.
  - Required: grant sequence 0,0,1,1,0,0,… with a 1-cycle bubble between grants.
- Simultaneous request after release:
  - Stimulus: src1 finishes; src0 and src1 both valid in the IDLE cycle.
  - Required: src0 granted, because rr_ptr = 0 after src1.
- Watchdog (macro on, TIMEOUT_CYCLES=8):
  - Stimulus: src0 valid, tx_ack held 0.
  - Required: timeout_error = 1 after 8 cycles; grant passes to valid src1; flag clears on clear_error.
- Reset mid-burst:
  - Stimulus: reset_n low during src0's 2nd word.
  - Required: all outputs 0 immediately; after release, src0 is re-granted and its held word is sent once.
- Enable gating:
  - Stimulus: enable low for 3 cycles with tx_ack = 1.
  - Required: no req_ack pulses, tx_word_valid = 0, state and counters unchanged.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM states, grant-index width, source limit and the round-robin pointer helper
package uart_tx_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int GID_W = 3;
    localparam int MAX_REQ = 8;
    function automatic logic [GID_W-1:0] next_rr(input logic [GID_W-1:0] ptr, input int n);
        return (int'(ptr) + 1 >= n) ? '0 : ptr + 1'b1;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: first set request at or above the pointer, wrapping past the top source
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GID_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [GID_W-1:0]   o_idx
);
    logic [NUM_REQ-1:0] w_sh;
    assign o_found = |i_req;
    // scan from the farthest offset down so the nearest requester wins
    always_comb begin
        o_idx = '0;
        w_sh = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sh = i_req >> ((int'(i_ptr) + k) % NUM_REQ);
            if (w_sh[0]) o_idx = GID_W'((int'(i_ptr) + k) % NUM_REQ);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locking share of the UART TX word channel; watchdog under UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int WORD_WIDTH     = 16,
    parameter int MAX_BURST      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] i_req_word,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [WORD_WIDTH-1:0]         o_tx_word,
    output logic                          o_tx_word_valid,
    input  logic                          i_tx_ack,
    output logic [GID_W-1:0]              o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout_error,
    input  logic                          i_clear_error
);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end

    state_t           r_state, w_next_state;
    logic [GID_W-1:0] r_rr_ptr, r_grant_id, w_pick_idx;
    logic [BW-1:0]    r_burst_cnt;
    logic             w_found, w_grant, w_gvalid, w_ack, w_burst_done, w_wd_fire, w_leave;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_grant         = r_state == GRANT;
    assign w_gvalid        = |(i_req_valid & (NUM_REQ'(1) << r_grant_id));
    assign o_tx_word       = w_grant ? WORD_WIDTH'(i_req_word >> (r_grant_id * WORD_WIDTH)) : '0;
    assign o_tx_word_valid = w_grant & w_gvalid & i_enable;
    assign w_ack           = o_tx_word_valid & i_tx_ack;
    assign o_req_ack       = w_ack ? NUM_REQ'(1) << r_grant_id : '0;
    assign w_burst_done    = (MAX_BURST != 0) && w_ack && (32'(r_burst_cnt) + 1 >= MAX_BURST);
    assign w_leave         = ~w_gvalid | w_burst_done | w_wd_fire;
    assign o_grant_id      = r_grant_id;
    assign o_busy          = w_grant;

    // next state: arbitrate when idle, drop the lock on release; frozen while disabled
    always_comb begin
        w_next_state = r_state;
        if (i_enable) w_next_state = (r_state == IDLE) ? (w_found ? GRANT : IDLE) : (w_leave ? IDLE : GRANT);
    end

    // state, grant index, burst count and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else if (i_enable) begin
            r_state <= w_next_state;
            if (!w_grant && w_found) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= '0;
            end else if (w_ack && r_burst_cnt != '1) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (w_grant && w_leave) r_rr_ptr <= next_rr(r_grant_id, NUM_REQ);
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wd_cnt;
    logic          r_timeout_error;
    assign w_wd_fire       = o_tx_word_valid & ~i_tx_ack & (32'(r_wd_cnt) == TIMEOUT_CYCLES - 1);
    assign o_timeout_error = r_timeout_error;

    // stall watchdog: counts unacked presented cycles, sticky error where a new timeout beats clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt        <= '0;
            r_timeout_error <= 1'b0;
        end else if (i_enable) begin
            r_wd_cnt        <= (o_tx_word_valid & ~i_tx_ack) ? r_wd_cnt + 1'b1 : '0;
            r_timeout_error <= w_wd_fire | (r_timeout_error & ~i_clear_error);
        end
    end
`else
    assign w_wd_fire       = 1'b0;
    assign o_timeout_error = i_clear_error & (TIMEOUT_CYCLES < 0);
`endif
endmodule
